// File: rtl/add_req_initiator.sv
// Initiator for the start/valid adder-responder protocol: issues one operand pair
// at a time, checks the returned sum and hands the result downstream.
module add_req_initiator #(
    parameter int W       = 10,
    parameter int TIMEOUT = 4,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    output logic             start,
    output logic [W-1:0]     op_a,
    output logic [W-1:0]     op_b,
    input  logic             rsp_valid,
    input  logic [W-1:0]     rsp_y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_y,
    output logic             out_err,
    output logic             timeout_err,
    output logic             spurious_err,
    input  logic             clr_err,
    output logic [CNT_W-1:0] txn_count,
    output logic [1:0]       dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid && ready are
    // both high; valid never depends on ready, and data is stable while valid waits.

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [W-1:0]      r_op_a;
    logic [W-1:0]      r_op_b;
    logic [W-1:0]      r_exp;
    logic [CW-1:0]     r_wait_cnt;
    logic              r_out_valid;
    logic [W-1:0]      r_out_y;
    logic              r_out_err;
    logic              r_timeout_err;
    logic              r_spurious_err;
    logic [CNT_W-1:0]  r_txn_count;

    logic [W-1:0]      w_sum;
    logic              w_in_fire;
    logic              w_out_fire;
    logic              w_rsp_take;
    logic              w_timeout;
    logic              w_spurious;

    assign w_sum      = in_a + in_b;
    assign w_in_fire  = (r_state == S_IDLE) && in_valid;
    assign w_out_fire = (r_state == S_HOLD) && r_out_valid && out_ready;
    assign w_rsp_take = (r_state == S_WAIT) && rsp_valid;
    assign w_timeout  = (r_state == S_WAIT) && !rsp_valid && (r_wait_cnt == TO_VAL);
    assign w_spurious = (r_state != S_WAIT) && rsp_valid;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (in_valid) w_next_state = S_ISSUE;
            S_ISSUE: w_next_state = S_WAIT;
            S_WAIT:  if (w_rsp_take || w_timeout) w_next_state = S_HOLD;
            S_HOLD:  if (w_out_fire) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_exp       <= '0;
            r_wait_cnt  <= '0;
            r_out_valid <= 1'b0;
            r_out_y     <= '0;
            r_out_err   <= 1'b0;
            r_txn_count <= '0;
        end else begin
            if (w_in_fire) begin
                r_op_a <= in_a;
                r_op_b <= in_b;
                r_exp  <= w_sum;
            end
            // Counter reads 1 in the first WAIT cycle, the nominal response slot.
            if (r_state == S_ISSUE) begin
                r_wait_cnt <= CW'(1);
            end else if (r_state == S_WAIT && r_wait_cnt != TO_VAL) begin
                r_wait_cnt <= r_wait_cnt + CW'(1);
            end
            if (w_rsp_take) begin
                r_out_y     <= rsp_y;
                r_out_err   <= (rsp_y != r_exp);
                r_out_valid <= 1'b1;
            end else if (w_timeout) begin
                r_out_y     <= '0;
                r_out_err   <= 1'b1;
                r_out_valid <= 1'b1;
            end else if (w_out_fire) begin
                r_out_valid <= 1'b0;
                r_txn_count <= r_txn_count + CNT_W'(1);
            end
        end
    end

    // Sticky flags: a set in the same cycle as clr_err takes priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_timeout_err  <= 1'b0;
            r_spurious_err <= 1'b0;
        end else begin
            if (w_timeout) begin
                r_timeout_err <= 1'b1;
            end else if (clr_err) begin
                r_timeout_err <= 1'b0;
            end
            if (w_spurious) begin
                r_spurious_err <= 1'b1;
            end else if (clr_err) begin
                r_spurious_err <= 1'b0;
            end
        end
    end

    // in_ready is gated by rst so every output reads 0 while reset is held.
    assign in_ready     = (r_state == S_IDLE) && !rst;
    assign start        = (r_state == S_ISSUE);
    assign op_a         = r_op_a;
    assign op_b         = r_op_b;
    assign out_valid    = r_out_valid;
    assign out_y        = r_out_y;
    assign out_err      = r_out_err;
    assign timeout_err  = r_timeout_err;
    assign spurious_err = r_spurious_err;
    assign txn_count    = r_txn_count;
    assign dbg_state    = r_state;

endmodule
